sim_frame_scheduler: RTL and testbench

SIM_FRAME_SCHEDULER -- requirements
Module: sim_frame_scheduler

---
 rtl/gravsim_pkg.sv | 18 +
 rtl/sync_edge_det.sv | 28 ++
 rtl/sim_frame_scheduler.sv | 142 ++++++++++++++
 tb/tb_sim_frame_scheduler.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/gravsim_pkg.sv
// Shared types and default keycodes for the gravity-simulation frame scheduler.
package gravsim_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_RUN,
        S_ABORT
    } sched_state_t;

    localparam logic [7:0] KEY_PAUSE_DEF = 8'd44;
    localparam logic [7:0] KEY_STEP_DEF  = 8'd17;
    localparam logic [7:0] KEY_UP_DEF    = 8'd26;
    localparam logic [7:0] KEY_DOWN_DEF  = 8'd22;
    localparam logic [7:0] KEY_LEFT_DEF  = 8'd4;
    localparam logic [7:0] KEY_RIGHT_DEF = 8'd7;

endpackage

// File: rtl/sync_edge_det.sv
// Two-flop synchroniser for an asynchronous level, followed by a registered
// one-cycle pulse on its synchronised falling edge.
module sync_edge_det (
    input  logic CLK,
    input  logic RESET,
    input  logic async_in,
    output logic fall_pulse
);

    logic sync_1;
    logic sync_2;
    logic sync_prev;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            sync_1     <= 1'b0;
            sync_2     <= 1'b0;
            sync_prev  <= 1'b0;
            fall_pulse <= 1'b0;
        end else begin
            sync_1     <= async_in;
            sync_2     <= sync_1;
            sync_prev  <= sync_2;
            fall_pulse <= sync_prev & ~sync_2;
        end
    end

endmodule

// File: rtl/sim_frame_scheduler.sv
// Frame scheduler: launches one physics run per VGA frame, with pause/step,
// overrun counting and timeout abort. Camera pan is built when SCHED_CAMERA_EN is defined.
module sim_frame_scheduler
    import gravsim_pkg::*;
#(
    parameter logic [7:0]  KEY_PAUSE   = KEY_PAUSE_DEF,
    parameter logic [7:0]  KEY_STEP    = KEY_STEP_DEF,
    parameter logic [7:0]  KEY_UP      = KEY_UP_DEF,
    parameter logic [7:0]  KEY_DOWN    = KEY_DOWN_DEF,
    parameter logic [7:0]  KEY_LEFT    = KEY_LEFT_DEF,
    parameter logic [7:0]  KEY_RIGHT   = KEY_RIGHT_DEF,
    parameter int unsigned TIMEOUT_CYC = 800000
) (
    input  logic               CLK,
    input  logic               RESET,
    input  logic               VGA_VS,
    input  logic [7:0]         keycode,
    input  logic               fsm_done,
    output logic               fsm_start,
    output logic               fsm_abort,
    output logic               paused,
    output logic               busy,
    output logic               timeout_err,
    output logic [31:0]        frame_cnt,
    output logic [15:0]        overrun_cnt,
    output logic signed [31:0] shift_x,
    output logic signed [31:0] shift_y
);

    localparam logic [31:0] TCNT_LAST = 32'(TIMEOUT_CYC - 1);

    sched_state_t state;
    logic         frame_tick;
    logic [7:0]   key_q;
    logic [7:0]   key_q2;
    logic         pause_press;
    logic         step_press;
    logic         step_pending;
    logic [31:0]  tcnt;

    sync_edge_det u_vs_sync (
        .CLK       (CLK),
        .RESET     (RESET),
        .async_in  (VGA_VS),
        .fall_pulse(frame_tick)
    );

    always_comb begin
        pause_press = (key_q == KEY_PAUSE) && (key_q2 != KEY_PAUSE);
        step_press  = (key_q == KEY_STEP)  && (key_q2 != KEY_STEP);
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state        <= S_IDLE;
            fsm_start    <= 1'b0;
            fsm_abort    <= 1'b0;
            paused       <= 1'b0;
            busy         <= 1'b0;
            timeout_err  <= 1'b0;
            step_pending <= 1'b0;
            frame_cnt    <= '0;
            overrun_cnt  <= '0;
            tcnt         <= '0;
            key_q        <= '0;
            key_q2       <= '0;
        end else begin
            fsm_start <= 1'b0;
            fsm_abort <= 1'b0;
            key_q     <= keycode;
            key_q2    <= key_q;

            case (state)
                S_IDLE: begin
                    if (frame_tick && (!paused || step_pending)) begin
                        state        <= S_START;
                        busy         <= 1'b1;
                        step_pending <= 1'b0;
                    end
                end
                S_START: begin
                    fsm_start <= 1'b1;
                    tcnt      <= '0;
                    state     <= S_RUN;
                end
                S_RUN: begin
                    if (frame_tick && (overrun_cnt != '1))
                        overrun_cnt <= overrun_cnt + 16'd1;
                    // Completion is checked before the timeout so a same-cycle done wins.
                    if (fsm_done) begin
                        state     <= S_IDLE;
                        busy      <= 1'b0;
                        frame_cnt <= frame_cnt + 32'd1;
                    end else if (tcnt == TCNT_LAST) begin
                        state <= S_ABORT;
                        busy  <= 1'b0;
                    end else begin
                        tcnt <= tcnt + 32'd1;
                    end
                end
                S_ABORT: begin
                    fsm_abort   <= 1'b1;
                    timeout_err <= 1'b1;
                    state       <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase

            if (step_press && paused)
                step_pending <= 1'b1;
            if (pause_press) begin
                paused <= !paused;
                if (paused)
                    step_pending <= 1'b0;
            end
        end
    end

`ifdef SCHED_CAMERA_EN
    always_ff @(posedge CLK) begin
        if (RESET) begin
            shift_x <= '0;
            shift_y <= '0;
        end else if (frame_tick) begin
            if (key_q == KEY_UP)
                shift_y <= shift_y + 32'sd1;
            else if (key_q == KEY_DOWN)
                shift_y <= shift_y - 32'sd1;
            else if (key_q == KEY_LEFT)
                shift_x <= shift_x - 32'sd1;
            else if (key_q == KEY_RIGHT)
                shift_x <= shift_x + 32'sd1;
        end
    end
`else
    // Pan keycodes have no function without the camera; they fold into a constant zero.
    localparam logic [31:0] PAN_KEYS = {KEY_UP, KEY_DOWN, KEY_LEFT, KEY_RIGHT};
    assign shift_x = PAN_KEYS & 32'h0;
    assign shift_y = '0;
`endif

endmodule

// File: tb/tb_sim_frame_scheduler.sv
// Self-checking bench for sim_frame_scheduler: directed scenarios plus random
// stimulus, compared every cycle against a behavioural reference model.
module tb_sim_frame_scheduler;

    localparam int unsigned TB_TIMEOUT = 120;
    localparam logic [7:0] K_PAUSE = 8'd44;
    localparam logic [7:0] K_STEP  = 8'd17;
    localparam logic [7:0] K_UP    = 8'd26;
    localparam logic [7:0] K_DOWN  = 8'd22;
    localparam logic [7:0] K_LEFT  = 8'd4;
    localparam logic [7:0] K_RIGHT = 8'd7;

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic        VGA_VS = 1'b1;
    logic [7:0]  keycode = '0;
    logic        fsm_done = 1'b0;
    logic        fsm_start, fsm_abort, paused, busy, timeout_err;
    logic [31:0] frame_cnt;
    logic [15:0] overrun_cnt;
    logic signed [31:0] shift_x, shift_y;

    sim_frame_scheduler #(.TIMEOUT_CYC(TB_TIMEOUT)) dut (
        .CLK(CLK), .RESET(RESET), .VGA_VS(VGA_VS), .keycode(keycode), .fsm_done(fsm_done),
        .fsm_start(fsm_start), .fsm_abort(fsm_abort), .paused(paused), .busy(busy),
        .timeout_err(timeout_err), .frame_cnt(frame_cnt), .overrun_cnt(overrun_cnt),
        .shift_x(shift_x), .shift_y(shift_y)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int failures = 0;
    int cyc_no = 0;
    int starts_seen = 0;
    int aborts_seen = 0;
    int last_start = 0;
    int last_abort = 0;

    // Reference model. run_age: -1 idle, 0 launching, N>=1 the Nth cycle of a run,
    // -2 the run just timed out and the abort is about to be signalled.
    int          run_age = -1;
    logic        m_paused, m_step, m_err, m_start, m_abort;
    logic [31:0] m_frame, m_sx, m_sy;
    logic [15:0] m_over;
    logic        vs_hist [4];
    logic [7:0]  key_hist [2];

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h cycle=%0d", tag, got, exp, cyc_no);
        end
    endtask

    task automatic model_edge();
        logic tick, pp, ps;
        logic [7:0] held;
        if (RESET) begin
            run_age = -1; m_paused = 0; m_step = 0; m_err = 0; m_start = 0; m_abort = 0;
            m_frame = 0; m_over = 0; m_sx = 0; m_sy = 0;
            for (int i = 0; i < 4; i++) vs_hist[i] = 1'b0;
            key_hist[0] = '0; key_hist[1] = '0;
            return;
        end
        // VS reaches the scheduler as a falling-edge tick three clocks after it is sampled.
        tick = vs_hist[3] && !vs_hist[2];
        held = key_hist[0];
        pp = (held == K_PAUSE) && (key_hist[1] != K_PAUSE);
        ps = (held == K_STEP) && (key_hist[1] != K_STEP);
        m_start = 0;
        m_abort = 0;
        if (run_age == -2) begin
            m_abort = 1; m_err = 1; run_age = -1;
        end else if (run_age == 0) begin
            m_start = 1; run_age = 1;
        end else if (run_age >= 1) begin
            if (tick && m_over != 16'hFFFF) m_over = m_over + 16'd1;
            if (fsm_done) begin
                m_frame = m_frame + 32'd1; run_age = -1;
            end else if (run_age == int'(TB_TIMEOUT)) begin
                run_age = -2;
            end else begin
                run_age++;
            end
        end else if (tick && (!m_paused || m_step)) begin
            run_age = 0; m_step = 0;
        end
        if (ps && m_paused) m_step = 1;
        if (pp) begin
            m_paused = !m_paused;
            if (!m_paused) m_step = 0;
        end
`ifdef SCHED_CAMERA_EN
        if (tick) begin
            if (held == K_UP) m_sy = m_sy + 32'd1;
            else if (held == K_DOWN) m_sy = m_sy - 32'd1;
            else if (held == K_LEFT) m_sx = m_sx - 32'd1;
            else if (held == K_RIGHT) m_sx = m_sx + 32'd1;
        end
`endif
        for (int i = 3; i > 0; i--) vs_hist[i] = vs_hist[i-1];
        vs_hist[0] = VGA_VS;
        key_hist[1] = key_hist[0];
        key_hist[0] = keycode;
    endtask

    task automatic check_outputs();
        check_val("fsm_start", 32'(fsm_start), 32'(m_start));
        check_val("fsm_abort", 32'(fsm_abort), 32'(m_abort));
        check_val("paused", 32'(paused), 32'(m_paused));
        check_val("busy", 32'(busy), 32'(run_age >= 0));
        check_val("timeout_err", 32'(timeout_err), 32'(m_err));
        check_val("frame_cnt", frame_cnt, m_frame);
        check_val("overrun_cnt", 32'(overrun_cnt), 32'(m_over));
        check_val("shift_x", shift_x, m_sx);
        check_val("shift_y", shift_y, m_sy);
    endtask

    // Called at a falling edge: drive, let one rising edge happen, compare at the next falling edge.
    task automatic cyc(input logic vs, input logic [7:0] kc, input logic done, input logic rst);
        VGA_VS = vs; keycode = kc; fsm_done = done; RESET = rst;
        @(posedge CLK);
        model_edge();
        @(negedge CLK);
        cyc_no++;
        check_outputs();
        if (fsm_start) begin starts_seen++; last_start = cyc_no; end
        if (fsm_abort) begin aborts_seen++; last_abort = cyc_no; end
    endtask

    task automatic do_reset();
        repeat (2) cyc(1'b1, 8'd0, 1'b0, 1'b1);
        repeat (4) cyc(1'b1, 8'd0, 1'b0, 1'b0);
    endtask

    task automatic frame_pulse(input logic [7:0] kc);
        repeat (4) cyc(1'b0, kc, 1'b0, 1'b0);
        repeat (4) cyc(1'b1, kc, 1'b0, 1'b0);
    endtask

    task automatic idle(input int n);
        repeat (n) cyc(1'b1, 8'd0, 1'b0, 1'b0);
    endtask

    initial begin
        int s0, a0;
        logic vs_r;
        logic [7:0] kc_r;
        logic [7:0] key_pool [8];
        key_pool = '{8'd0, 8'd0, K_PAUSE, K_STEP, K_UP, K_DOWN, K_LEFT, K_RIGHT};
        @(negedge CLK);
        do_reset();

        // Unpaused frame: start two cycles after the tick, done 100 cycles after start.
        frame_pulse(8'd0);
        repeat (96) cyc(1'b1, 8'd0, 1'b0, 1'b0);
        cyc(1'b1, 8'd0, 1'b1, 1'b0);
        check_val("d032_gap", 32'(cyc_no - last_start), 32'd100);
        check_val("d032_frame", frame_cnt, 32'd1);
        check_val("d032_busy", 32'(busy), 32'd0);

        // Pause blocks ticks; one step press yields exactly one run.
        cyc(1'b1, 8'd0, 1'b0, 1'b0);
        repeat (2) cyc(1'b1, K_PAUSE, 1'b0, 1'b0);
        cyc(1'b1, 8'd0, 1'b0, 1'b0);
        check_val("d033_paused", 32'(paused), 32'd1);
        s0 = starts_seen;
        repeat (3) frame_pulse(8'd0);
        idle(10);
        check_val("d033_nostart", 32'(starts_seen - s0), 32'd0);
        repeat (2) cyc(1'b1, K_STEP, 1'b0, 1'b0);
        repeat (2) cyc(1'b1, K_STEP, 1'b0, 1'b0);
        idle(2);
        frame_pulse(8'd0);
        idle(10);
        cyc(1'b1, 8'd0, 1'b1, 1'b0);
        frame_pulse(8'd0);
        idle(10);
        check_val("d033_onestart", 32'(starts_seen - s0), 32'd1);
        repeat (2) cyc(1'b1, K_PAUSE, 1'b0, 1'b0);
        idle(2);
        check_val("d033_unpaused", 32'(paused), 32'd0);

        // Timeout: abort lands TIMEOUT_CYC+1 cycles after the start pulse.
        a0 = aborts_seen;
        frame_pulse(8'd0);
        idle(TB_TIMEOUT + 10);
        check_val("d034_aborts", 32'(aborts_seen - a0), 32'd1);
        check_val("d034_gap", 32'(last_abort - last_start), 32'(TB_TIMEOUT + 1));
        check_val("d034_err", 32'(timeout_err), 32'd1);
        check_val("d034_busy", 32'(busy), 32'd0);

        // Two ticks during one run count as overruns and launch nothing.
        do_reset();
        s0 = starts_seen;
        repeat (3) frame_pulse(8'd0);
        cyc(1'b1, 8'd0, 1'b1, 1'b0);
        idle(5);
        check_val("d035_overrun", 32'(overrun_cnt), 32'd2);
        check_val("d035_starts", 32'(starts_seen - s0), 32'd1);
        check_val("d035_frame", frame_cnt, 32'd1);

        // Camera pan: KEY_UP held over five ticks.
        do_reset();
        repeat (3) cyc(1'b1, K_UP, 1'b0, 1'b0);
        repeat (5) frame_pulse(K_UP);
        repeat (4) cyc(1'b1, K_UP, 1'b0, 1'b0);
`ifdef SCHED_CAMERA_EN
        check_val("d036_shift_y", shift_y, 32'd5);
`else
        check_val("d036_shift_y", shift_y, 32'd0);
`endif
        check_val("d036_shift_x", shift_x, 32'd0);

        // Reset mid-run abandons the run silently.
        do_reset();
        a0 = aborts_seen;
        frame_pulse(8'd0);
        idle(10);
        check_val("d037_busy_pre", 32'(busy), 32'd1);
        cyc(1'b1, 8'd0, 1'b0, 1'b1);
        check_val("d037_start", 32'(fsm_start), 32'd0);
        check_val("d037_abort", 32'(fsm_abort), 32'd0);
        check_val("d037_busy", 32'(busy), 32'd0);
        check_val("d037_paused", 32'(paused), 32'd0);
        check_val("d037_err", 32'(timeout_err), 32'd0);
        check_val("d037_frame", frame_cnt, 32'd0);
        check_val("d037_overrun", 32'(overrun_cnt), 32'd0);
        idle(TB_TIMEOUT + 20);
        check_val("d037_noabort", 32'(aborts_seen - a0), 32'd0);

        // Randomised traffic against the model.
        vs_r = 1'b1;
        kc_r = 8'd0;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 5) == 0) vs_r = !vs_r;
            if ($urandom_range(0, 9) == 0) begin
                if ($urandom_range(0, 7) == 0) kc_r = 8'($urandom);
                else kc_r = key_pool[$urandom_range(0, 7)];
            end
            cyc(vs_r, kc_r, ($urandom_range(0, 39) == 0), ($urandom_range(0, 999) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
